lag_result_stats: RTL
=====================

// Module: lag_result_stats
// PURPOSE
// Statistics stage downstream of the lag measurement capture. Consumes each captured 5-digit
// packed-BCD latency (units of 0.01 ms, 000.00..999.99 ms) and keeps last/min/max plus a
// block average over 2**AVG_LOG2 samples for the on-screen result overlay. Digit-serial
// BCD->binary conversion in, sequential double-dabble binary->BCD out; single clock domain.
// PARAMETERS
// AVG_LOG2  4  log2 of samples per averaging block (window 16); legal range 1..7
// PORTS
// clock         in   1   system clock
// reset         in   1   asynchronous, active-high reset
// clear         in   1   synchronous stats clear, highest priority
// sample_valid  in   1   one-cycle strobe: sample_bcd holds a new measurement
// sample_bcd    in   20  packed BCD latency, digit 4 in [19:16] .. digit 0 in [3:0]
// busy          out  1   processing; samples offered while high are dropped
// dropped       out  1   one-cycle pulse: sample_valid seen while busy
// bcd_error     out  1   one-cycle pulse: sample rejected, some nibble > 9
// last_bcd      out  20  most recent accepted sample
// min_bcd       out  20  smallest accepted sample since reset/clear
// max_bcd       out  20  largest accepted sample since reset/clear
// avg_bcd       out  20  floor average of the last completed block, BCD
// avg_valid     out  1   one-cycle pulse when avg_bcd updates
// sample_count  out  8   accepted samples since reset/clear, saturates at 255
// BEHAVIOUR
// - Reset/clear values: busy=0, dropped=0, bcd_error=0, last=0, min=0x99999, max=0,
//   avg=0, avg_valid=0, count=0; internal sum and block counter = 0; FSM -> IDLE.
// - clear aborts any in-flight operation; clear with sample_valid in same cycle: clear wins,
//   sample ignored, no dropped/bcd_error pulse.
// - FSM: IDLE -> CONV (5 cycles) -> ACC (1) -> IDLE, or ACC -> DABBLE (17) -> IDLE.
// - busy is registered, = (state != IDLE).
// - Accept at cycle T: sample_valid && !busy && all nibbles <= 9. Any nibble > 9: bcd_error
//   pulses at T+1, FSM stays IDLE, nothing else changes.
// - CONV T+1..T+5: bin = bin*10 + digit, MS digit first; bin is 17 bits (max 99999).
// - ACC T+6: sum += bin (sum width 17+AVG_LOG2); last=sample; min/max updated by unsigned
//   compare of packed BCD (valid for BCD); equal values leave min/max unchanged.
//   count and block counter increment. All visible at T+7.
// - Block not yet full: busy low at T+7, next sample acceptable at T+7.
// - Block full (block counter reaches 2**AVG_LOG2): avg_bin = sum >> AVG_LOG2 (floor);
//   sum and block counter cleared; DABBLE T+7..T+23, one shift-add-3 step per cycle.
// - avg_bcd loaded and avg_valid pulses visible at T+24; busy low at T+24.
// - sample_valid while busy: dropped pulses next cycle; sample discarded, no state change.
// - count saturates at 255; block averaging keeps running past saturation.
// - Async reset mid-operation: everything returns to reset values immediately.
// - No overflow possible: sum <= 99999 * 2**AVG_LOG2 fits in 17+AVG_LOG2 bits.
// TESTING
// 1 reset asserted then released -> min=0x99999, max=0, last=0, avg=0, count=0, busy=0.
// 2 samples 0x01234, 0x00567, 0x02000 each after busy low -> last=0x02000, min=0x00567,
//   max=0x02000, count=3; busy high exactly 6 cycles per sample.
// 3 AVG_LOG2=4: 8x 0x00150 then 8x 0x00251 -> avg_valid pulses T+24 after 16th accept,
//   avg_bcd=0x00200 (floor of 200.5); busy high 23 cycles for that sample.
// 4 sample_valid at T+3 during a conversion -> dropped pulse at T+4; count, min, max, last
//   reflect only the first sample.
// 5 sample_bcd=0x0A000 -> bcd_error pulse next cycle, busy stays 0, count unchanged;
//   then 0x99999 accepted -> max=0x99999.
// 6 clear asserted during DABBLE of a full block -> all stats at clear values, avg_valid
//   never pulses; next 16 samples of 0x00042 -> avg_bcd=0x00042.

Source files
------------

// File: rtl/lag_result_stats.sv
// Latency statistics: packed-BCD samples in, last/min/max/count and a block
// average (binary sum, double-dabble back to BCD) out for the result overlay.
module lag_result_stats #(
  parameter int AVG_LOG2 = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        sample_valid,
  input  logic [19:0] sample_bcd,
  output logic        busy,
  output logic        dropped,
  output logic        bcd_error,
  output logic [19:0] last_bcd,
  output logic [19:0] min_bcd,
  output logic [19:0] max_bcd,
  output logic [19:0] avg_bcd,
  output logic        avg_valid,
  output logic [7:0]  sample_count
);

  localparam int SUM_W = 17 + AVG_LOG2;
  localparam int BLK_W = AVG_LOG2 + 1;
  localparam logic [BLK_W-1:0] BLK_FULL = BLK_W'(1 << AVG_LOG2);

  typedef enum logic [1:0] {IDLE, CONV, ACC, DABBLE} state_t;

  state_t             state, state_nx;
  logic [19:0]        samp;
  logic [2:0]         conv_idx;
  logic [16:0]        bin;
  logic [SUM_W-1:0]   sum;
  logic [BLK_W-1:0]   blk;
  logic [16:0]        dab_bin;
  logic [19:0]        dab_bcd;
  logic [4:0]         dab_cnt;

  logic               accept;
  logic [3:0]         digit;
  logic [16:0]        bin_next;
  logic [SUM_W-1:0]   sum_acc;
  logic [BLK_W-1:0]   blk_inc;
  logic               blk_full;
  logic [19:0]        dab_next;

  function automatic logic bcd_ok(input logic [19:0] v);
    for (int i = 0; i < 5; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
  function automatic logic [19:0] dabble_step(input logic [19:0] b, input logic in_bit);
    logic [19:0] a;
    a = b;
    for (int i = 0; i < 5; i++)
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    return {a[18:0], in_bit};
  endfunction

  always_comb begin
    digit = 4'd0;
    case (conv_idx)
      3'd0:    digit = samp[19:16];
      3'd1:    digit = samp[15:12];
      3'd2:    digit = samp[11:8];
      3'd3:    digit = samp[7:4];
      default: digit = samp[3:0];
    endcase
  end

  assign accept   = sample_valid && !busy && bcd_ok(sample_bcd);
  assign bin_next = {bin[13:0], 3'b000} + {bin[15:0], 1'b0} + 17'(digit);
  assign sum_acc  = sum + SUM_W'(bin);
  assign blk_inc  = blk + BLK_W'(1);
  assign blk_full = (blk_inc == BLK_FULL);
  assign dab_next = dabble_step(dab_bcd, dab_bin[16]);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CONV;
      CONV:    if (conv_idx == 3'd4) state_nx = ACC;
      ACC:     state_nx = blk_full ? DABBLE : IDLE;
      DABBLE:  if (dab_cnt == 5'd16) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dropped <= 1'b0;  bcd_error <= 1'b0;  avg_valid <= 1'b0;
      last_bcd <= '0;   min_bcd <= 20'h99999;  max_bcd <= '0;
      avg_bcd <= '0;    sample_count <= '0;
      samp <= '0;  conv_idx <= '0;  bin <= '0;  sum <= '0;  blk <= '0;
      dab_bin <= '0;  dab_bcd <= '0;  dab_cnt <= '0;
    end else if (clear) begin
      dropped <= 1'b0;  bcd_error <= 1'b0;  avg_valid <= 1'b0;
      last_bcd <= '0;   min_bcd <= 20'h99999;  max_bcd <= '0;
      avg_bcd <= '0;    sample_count <= '0;
      samp <= '0;  conv_idx <= '0;  bin <= '0;  sum <= '0;  blk <= '0;
      dab_bin <= '0;  dab_bcd <= '0;  dab_cnt <= '0;
    end else begin
      dropped   <= sample_valid && busy;
      bcd_error <= sample_valid && !busy && !bcd_ok(sample_bcd);
      avg_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          samp     <= sample_bcd;
          conv_idx <= 3'd0;
          bin      <= '0;
        end
        // Digit-serial BCD -> binary, most significant digit first
        CONV: begin
          bin      <= bin_next;
          conv_idx <= conv_idx + 3'd1;
        end
        // Packed BCD orders like its value, so a plain unsigned compare suffices
        ACC: begin
          last_bcd     <= samp;
          if (samp < min_bcd) min_bcd <= samp;
          if (samp > max_bcd) max_bcd <= samp;
          sample_count <= sat_inc(sample_count);
          if (blk_full) begin
            sum     <= '0;
            blk     <= '0;
            dab_bin <= sum_acc[AVG_LOG2 +: 17];
            dab_bcd <= '0;
            dab_cnt <= '0;
          end else begin
            sum <= sum_acc;
            blk <= blk_inc;
          end
        end
        // Binary average -> BCD, one bit per cycle over 17 cycles
        DABBLE: begin
          dab_bcd <= dab_next;
          dab_bin <= {dab_bin[15:0], 1'b0};
          dab_cnt <= dab_cnt + 5'd1;
          if (dab_cnt == 5'd16) begin
            avg_bcd   <= dab_next;
            avg_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
